// File: rtl/ex3_conv_seq_pkg.sv
// Shared types and constants for the byte-serial BCD <-> Excess-3 converter.
package ex3_conv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // Adder operands: decode adds 0xCC + 1 = 0xCD, i.e. subtracts 0x33 mod 256.
  localparam logic [7:0] ENC_B   = 8'h33;
  localparam logic       ENC_CIN = 1'b0;
  localparam logic [7:0] DEC_B   = 8'hCC;
  localparam logic       DEC_CIN = 1'b1;

  localparam logic [3:0] ENC_NIB_MAX = 4'd9;
  localparam logic [3:0] DEC_NIB_MIN = 4'd3;
  localparam logic [3:0] DEC_NIB_MAX = 4'd12;

  function automatic logic nibble_illegal(input logic [3:0] nib, input logic dir);
    if (dir) begin
      return (nib < DEC_NIB_MIN) || (nib > DEC_NIB_MAX);
    end
    return nib > ENC_NIB_MAX;
  endfunction

  function automatic logic byte_illegal(input logic [7:0] b, input logic dir);
    return nibble_illegal(b[3:0], dir) || nibble_illegal(b[7:4], dir);
  endfunction

endpackage

// File: rtl/ex3_conv_seq_adder.sv
// 8-bit ripple-carry full-adder chain shared by the converter.
module B_TO_Ex3_design (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < 8; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end
    Cout = c[8];
  end

endmodule

// File: rtl/ex3_conv_seq.sv
// Byte-serial BCD <-> Excess-3 word converter with valid/ready on both sides.
module ex3_conv_seq
  import ex3_conv_seq_pkg::*;
#(
  parameter int unsigned N_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_dir,
  input  logic [8*N_BYTES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*N_BYTES-1:0]   out_data,
  output logic                   out_err,
  output logic                   busy
);

  localparam int unsigned W     = 8 * N_BYTES;
  localparam int unsigned IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  conv_state_e      state_q, state_d;
  logic [W-1:0]     src_q, src_d;
  logic [W-1:0]     result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic [7:0] src_byte;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       unused_cout;

  assign src_byte = src_q[idx_q*8 +: 8];
  assign add_b    = dir_q ? DEC_B : ENC_B;
  assign add_cin  = dir_q ? DEC_CIN : ENC_CIN;

  B_TO_Ex3_design u_adder (
    .A    (src_byte),
    .B    (add_b),
    .Cin  (add_cin),
    .S    (add_sum),
    .Cout (unused_cout)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    result_d  = result_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          src_d   = in_data;
          dir_d   = in_dir;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy                     = 1'b1;
        result_d[idx_q*8 +: 8]   = add_sum;
        err_d                    = err_q | byte_illegal(src_byte, dir_q);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  assign out_data = result_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_ex3_conv_seq.sv
// Directed bench for ex3_conv_seq: vector table plus backpressure and reset sequences.
module tb_ex3_conv_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_dir;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex3_conv_seq #(.N_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  typedef struct {
    logic         dir;
    logic [W-1:0] data;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait (bounded) for in_ready, and release in_valid after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic dir);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    for (int k = 0; k < 20 && !in_ready; k++) step();
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_data;

    vecs[0] = '{1'b0, 32'h12345678, 32'h456789AB, 1'b0};
    vecs[1] = '{1'b1, 32'h456789AB, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 32'h333C3C3C, 32'h00090909, 1'b0};
    vecs[3] = '{1'b0, 32'h0000000A, 32'h3333333D, 1'b1};
    vecs[4] = '{1'b1, 32'h33333330, 32'h000000FD, 1'b1};
    vecs[5] = '{1'b0, 32'h99999999, 32'hCCCCCCCC, 1'b0};
    vecs[6] = '{1'b1, 32'hCCCCCCCC, 32'h99999999, 1'b0};
    vecs[7] = '{1'b1, 32'h3333333D, 32'h0000000A, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_dir    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_out_data",  out_data,           32'h0);
    chk("rst_out_err",   {31'b0, out_err},   32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, vecs[i].dir);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), lat, NB);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'b0, out_err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_valid_drop", i), {31'b0, out_valid}, 32'd0);
      chk($sformatf("vec%0d_idle_ready", i), {31'b0, in_ready}, 32'd1);
    end

    // out_ready already high on entry: exactly one DONE cycle.
    out_ready = 1'b1;
    send(32'h00000000, 1'b0);
    wait_valid(lat);
    chk("fast_latency", lat, NB);
    chk("fast_data", out_data, 32'h33333333);
    step();
    chk("fast_one_done", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Backpressure with a pending word on the input.
    send(32'h12345678, 1'b0);
    wait_valid(lat);
    chk("bp_latency", lat, NB);
    in_valid  = 1'b1;
    in_data   = 32'h99999999;
    in_dir    = 1'b0;
    held_data = out_data;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp%0d_valid", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_data", c), out_data, 32'h456789AB);
      chk($sformatf("bp%0d_err", c), {31'b0, out_err}, 32'd0);
      chk($sformatf("bp%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
    end
    chk("bp_held", out_data, held_data);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_pending_busy", {31'b0, busy}, 32'd1);
    wait_valid(lat);
    chk("bp_pending_latency", lat, NB);
    chk("bp_pending_data", out_data, 32'hCCCCCCCC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset with idx == 2.
    send(32'h12345678, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    {31'b0, out_valid}, 32'd0);
    chk("mid_rst_data",     out_data,           32'h0);
    chk("mid_rst_err",      {31'b0, out_err},   32'd0);
    chk("mid_rst_busy",     {31'b0, busy},      32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready},  32'd1);
    #2;
    rst_n = 1'b1;
    step();
    send(32'h12345678, 1'b0);
    wait_valid(lat);
    chk("post_rst_latency", lat, NB);
    chk("post_rst_data", out_data, 32'h456789AB);
    chk("post_rst_err", {31'b0, out_err}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex3_conv_seq.md
# ex3_conv_seq

Sequencer that converts a packed multi-digit BCD word to Excess-3, or Excess-3 back to BCD, by time-sharing a single 8-bit ripple-carry adder over the word one byte (two digits) per cycle. It sits between a valid/ready producer and a valid/ready consumer. It flags any digit that is illegal for the selected direction.

## Interface

Parameters:
- N_BYTES, default 4: bytes per word; word width W = 8*N_BYTES, digits = 2*N_BYTES; legal values 1..8.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word (high only in IDLE).
- in_dir  input  1  0 = BCD→Excess-3, 1 = Excess-3→BCD; sampled with in_data.
- in_data  input  W  packed digits; digit 0 in [3:0].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  converted word.
- out_err  output  1  at least one digit of the accepted word was illegal.
- busy  output  1  high in RUN or DONE.

## Operation

- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid & in_ready) latches in_data, in_dir, idx=0, err=0, and moves to RUN.
- RUN:
  - Each cycle the adder operand A = source byte[idx].
  - Encode drives adder B=0x33, Cin=0. Decode drives B=0xCC, Cin=1, which adds 0xCD (−0x33 mod 256).
  - Adder sum is written to result byte[idx]. Adder carry-out is ignored.
  - err |= illegal(byte[idx]). The digit is illegal when either nibble >9 for encode, or either nibble <3 or >12 for decode.
  - idx increments. When idx==N_BYTES−1, the FSM moves to DONE.
- DONE:
  - out_valid=1; out_data and out_err hold stable.
  - On out_ready, the FSM moves to IDLE.
  - in_valid is ignored in DONE.
- Illegal digits do not stop conversion. The raw adder sum for those digits is emitted, with out_err=1.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, out_err=0, idx=0.
- Reset asserted mid-RUN or mid-DONE aborts the word. The partial result is discarded and all outputs return to their reset values immediately (asynchronously).

## Timing

- If the acceptance edge is T, RUN covers edges T+1..T+N_BYTES. out_valid is first high in the cycle after edge T+N_BYTES, so latency is N_BYTES cycles after acceptance.
- Minimum period per word is N_BYTES+2 cycles: one acceptance cycle in IDLE, N_BYTES RUN cycles, and one DONE cycle with out_ready=1.
- The result registers update only in RUN. out_data is registered, with no combinational path from in_data to outputs.
- in_ready depends only on state and has no combinational path from out_ready.
- If out_ready is already high when DONE is entered, the FSM spends exactly one cycle in DONE.
- The adder path is combinational within one cycle: 8-bit ripple plus the byte mux.

## Structure

- A shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the constants ENC_B=8'h33, ENC_CIN=1'b0, DEC_B=8'hCC, DEC_CIN=1'b1;
  - the nibble-legality bounds.
- The block has one sub-module: a single instance of the team's 8-bit full-adder chain B_TO_Ex3_design, with Cout left unused.
- The byte-select mux, legality check, and FSM are local to ex3_conv_seq.

## Test plan

- Encode: in_dir=0, in_data=0x12345678 → out_data=0x45678 9AB (0x456789AB), out_err=0. out_valid rises 4 cycles after acceptance.
- Decode: in_dir=1, in_data=0x456789AB → out_data=0x12345678, out_err=0. Also in_data=0x333C3C3C → out_data=0x00090909.
- Illegal encode: in_dir=0, in_data=0x0000000A → out_data=0x3333333D, out_err=1.
- Illegal decode: in_dir=1, in_data=0x33333330 → out_data=0x000000FD, out_err=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1.
  - Expected: out_valid, out_data, and out_err stay stable, and in_ready=0.
  - When out_ready=1, the block returns to IDLE, then accepts the pending word.
- Reset mid-run: drop rst_n while idx=2.
  - Expected: out_valid=0, out_data=0, out_err=0, busy=0, in_ready=1.
  - A subsequent 0x12345678 encode after reset yields 0x456789AB.
